// File: rtl/rgbw_frame_decoder.sv
// Frames spiSlave bytes with cs, validates opcode/length and commits RGBW/intensity atomically;
// `RGBW_DECODER_CHKSUM_EN adds a trailing XOR checksum byte. Commit 4 clk after cs rises, no backpressure.
module rgbw_frame_decoder #(
  parameter logic [7:0] RST_INTENSITY = 8'hFF,
  parameter logic [7:0] RST_COLOR     = 8'h00
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cs,
  input  logic       rdy,
  input  logic [7:0] data,
  output logic [7:0] red,
  output logic [7:0] green,
  output logic [7:0] blue,
  output logic [7:0] white,
  output logic [7:0] intensity,
  output logic       upd,
  output logic       err,
  output logic       err_flag
);

`ifdef RGBW_DECODER_CHKSUM_EN
  localparam bit CHK_EN = 1'b1;
`else
  localparam bit CHK_EN = 1'b0;
`endif

  localparam logic [1:0] OP_NOP   = 2'b00;
  localparam logic [1:0] OP_COLOR = 2'b01;
  localparam logic [1:0] OP_INTEN = 2'b10;

  typedef enum logic [2:0] {S_IDLE, S_CMD, S_PAYLOAD, S_DONE, S_DROP} state_t;

  // Synchronizer runs through reset so a cs already low at release is not seen as a fresh fall
  logic cs_m, cs_s, cs_d;
  logic rise_q, fall_q;

  state_t     state_q, state_n;
  logic [2:0] cnt_q, cnt_n;
  logic [1:0] op_q, op_n;
  logic [7:0] chk_q, chk_n;
  logic [7:0] shadow_q [4];
  logic [7:0] shadow_n [4];
  logic [2:0] need;
  logic       byte_ok;
  logic       commit_color, commit_inten, err_c;

  always_ff @(posedge clk) begin
    cs_m <= cs;
    cs_s <= cs_m;
    cs_d <= cs_s;
  end

  assign need = (op_q == OP_COLOR) ? 3'd4 : 3'd1;
  // A byte landing in the edge-detect cycle still belongs to the closing frame
  assign byte_ok = rdy && (!cs_s || rise_q);

  always_comb begin
    state_n      = state_q;
    cnt_n        = cnt_q;
    op_n         = op_q;
    chk_n        = chk_q;
    shadow_n     = shadow_q;
    commit_color = 1'b0;
    commit_inten = 1'b0;
    err_c        = 1'b0;

    if (byte_ok) begin
      case (state_q)
        S_CMD: begin
          op_n  = data[7:6];
          chk_n = data;
          cnt_n = 3'd0;
          case (data[7:6])
            OP_COLOR, OP_INTEN: state_n = S_PAYLOAD;
            OP_NOP:             state_n = S_DONE;
            default:            state_n = S_DROP;
          endcase
        end
        S_PAYLOAD: begin
          if (CHK_EN && cnt_q == need) begin
            state_n = (data == chk_q) ? S_DONE : S_DROP;
          end else begin
            shadow_n[cnt_q[1:0]] = data;
            chk_n = chk_q ^ data;
            cnt_n = cnt_q + 3'd1;
            if (!CHK_EN && cnt_n == need) state_n = S_DONE;
          end
        end
        S_DONE:  state_n = S_DROP;
        default: ;
      endcase
    end

    if (rise_q) begin
      case (state_n)
        S_DONE: begin
          commit_color = (op_n == OP_COLOR);
          commit_inten = (op_n == OP_INTEN);
        end
        S_PAYLOAD, S_DROP: err_c = 1'b1;
        default: ;
      endcase
      state_n = S_IDLE;
      cnt_n   = 3'd0;
    end else if (fall_q) begin
      state_n = S_CMD;
      cnt_n   = 3'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      rise_q    <= 1'b0;
      fall_q    <= 1'b0;
      state_q   <= S_IDLE;
      cnt_q     <= 3'd0;
      op_q      <= OP_NOP;
      chk_q     <= 8'h00;
      for (int i = 0; i < 4; i++) shadow_q[i] <= 8'h00;
      red       <= RST_COLOR;
      green     <= RST_COLOR;
      blue      <= RST_COLOR;
      white     <= RST_COLOR;
      intensity <= RST_INTENSITY;
      upd       <= 1'b0;
      err       <= 1'b0;
      err_flag  <= 1'b0;
    end else begin
      rise_q   <= cs_s & ~cs_d;
      fall_q   <= ~cs_s & cs_d;
      state_q  <= state_n;
      cnt_q    <= cnt_n;
      op_q     <= op_n;
      chk_q    <= chk_n;
      shadow_q <= shadow_n;
      upd      <= commit_color | commit_inten;
      err      <= err_c;
      if (err_c) err_flag <= 1'b1;
      if (commit_color) begin
        red   <= shadow_n[0];
        green <= shadow_n[1];
        blue  <= shadow_n[2];
        white <= shadow_n[3];
      end
      if (commit_inten) intensity <= shadow_n[0];
    end
  end

endmodule

// File: tb/tb_rgbw_frame_decoder.sv
// Randomized bench for rgbw_frame_decoder against a frame-level model of the decode rules.
`timescale 1ns/1ps
module tb_rgbw_frame_decoder;

`ifdef RGBW_DECODER_CHKSUM_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic       r_Clk = 1'b0;
  logic       reset = 1'b0;
  logic       cs    = 1'b1;
  logic       rdy   = 1'b0;
  logic [7:0] data  = 8'h00;
  logic [7:0] red, green, blue, white, intensity;
  logic       upd, err, err_flag;

  always #5 r_Clk = ~r_Clk;

  rgbw_frame_decoder dut (
    .clk(r_Clk), .reset(reset), .cs(cs), .rdy(rdy), .data(data),
    .red(red), .green(green), .blue(blue), .white(white), .intensity(intensity),
    .upd(upd), .err(err), .err_flag(err_flag)
  );

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  always @(posedge r_Clk) cyc <= cyc + 1;

  logic [7:0] e_red, e_green, e_blue, e_white, e_int;
  logic       e_flag;
  int         pend_cyc = -1;
  int         pend_kind = 0;
  logic [7:0] pend_v [4];
  bit         cmp_on = 1'b0;
  int         upd_cnt = 0;
  int         err_cnt = 0;
  logic [7:0] fq [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Expected outputs change exactly when the model says the frame commits or is dropped
  always @(negedge r_Clk) begin
    bit eu, ee;
    eu = 1'b0;
    ee = 1'b0;
    if (cmp_on) begin
      if (cyc == pend_cyc) begin
        case (pend_kind)
          1: begin e_red = pend_v[0]; e_green = pend_v[1]; e_blue = pend_v[2]; e_white = pend_v[3]; eu = 1'b1; end
          2: begin e_int = pend_v[0]; eu = 1'b1; end
          3: begin e_flag = 1'b1; ee = 1'b1; end
          default: ;
        endcase
        pend_cyc = -1;
      end
      check("red", red, e_red);
      check("green", green, e_green);
      check("blue", blue, e_blue);
      check("white", white, e_white);
      check("intensity", intensity, e_int);
      check("upd", upd, eu);
      check("err", err, ee);
      check("err_flag", err_flag, e_flag);
      if (upd) upd_cnt++;
      if (err) err_cnt++;
    end
  end

  // 0 none, 1 colour commit, 2 intensity commit, 3 discard with error
  function automatic int model_kind();
    int need, total;
    logic [7:0] x;
    if (fq.size() == 0) return 0;
    case (fq[0][7:6])
      2'b01:   need = 4;
      2'b10:   need = 1;
      2'b00:   need = 0;
      default: return 3;
    endcase
    total = 1 + need + ((CHK && need > 0) ? 1 : 0);
    if (fq.size() != total) return 3;
    if (CHK && need > 0) begin
      x = 8'h00;
      for (int i = 0; i <= need; i++) x ^= fq[i];
      if (fq[need + 1] != x) return 3;
    end
    for (int i = 0; i < need; i++) pend_v[i] = fq[i + 1];
    return (need == 0) ? 0 : ((need == 4) ? 1 : 2);
  endfunction

  task automatic tick();
    @(posedge r_Clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rdy = 1'b1;
    data = b;
    tick();
    rdy = 1'b0;
    data = 8'($urandom);
    repeat ($urandom_range(0, 2)) tick();
  endtask

  task automatic set_frame(input int n, input logic [7:0] b0, input logic [7:0] b1,
                           input logic [7:0] b2, input logic [7:0] b3, input logic [7:0] b4);
    fq.delete();
    if (n > 0) fq.push_back(b0);
    if (n > 1) fq.push_back(b1);
    if (n > 2) fq.push_back(b2);
    if (n > 3) fq.push_back(b3);
    if (n > 4) fq.push_back(b4);
  endtask

  task automatic send_frame(input bit add_chk);
    logic [7:0] x;
    if (add_chk && CHK && fq.size() > 0 && fq[0][7:6] != 2'b00) begin
      x = 8'h00;
      foreach (fq[i]) x ^= fq[i];
      fq.push_back(x);
    end
    cs = 1'b0;
    repeat (4) tick();
    foreach (fq[i]) send_byte(fq[i]);
    repeat ($urandom_range(0, 2)) tick();
    cs = 1'b1;
    pend_kind = model_kind();
    if (pend_kind != 0) pend_cyc = cyc + 4;
    repeat (6) tick();
    // Stray byte strobe while deselected must be ignored
    send_byte(8'h40);
    repeat (2) tick();
  endtask

  task automatic do_reset();
    cmp_on = 1'b0;
    reset = 1'b0;
    repeat (3) tick();
    reset = 1'b1;
    e_red = 8'h00; e_green = 8'h00; e_blue = 8'h00; e_white = 8'h00;
    e_int = 8'hFF; e_flag = 1'b0;
    pend_cyc = -1;
    cmp_on = 1'b1;
  endtask

  initial begin
    int u0, e0;
    logic [1:0] op;
    repeat (2) tick();
    do_reset();
    tick();
    check("rst_red", red, 8'h00);
    check("rst_intensity", intensity, 8'hFF);
    check("rst_upd", upd, 1'b0);
    check("rst_err", err, 1'b0);
    check("rst_err_flag", err_flag, 1'b0);

    u0 = upd_cnt; e0 = err_cnt;
    set_frame(5, 8'h40, 8'h12, 8'h34, 8'h56, 8'h78); send_frame(1'b1);
    check("color_red", red, 8'h12);
    check("color_green", green, 8'h34);
    check("color_blue", blue, 8'h56);
    check("color_white", white, 8'h78);
    check("color_int", intensity, 8'hFF);
    check("color_upd_count", upd_cnt - u0, 1);
    check("color_err_count", err_cnt - e0, 0);

    e0 = err_cnt;
    set_frame(3, 8'h40, 8'h11, 8'h22, 8'h00, 8'h00); send_frame(1'b0);
    check("short_red", red, 8'h12);
    check("short_err_count", err_cnt - e0, 1);
    check("short_err_flag", err_flag, 1'b1);

    set_frame(2, 8'h80, 8'h20, 8'h00, 8'h00, 8'h00); send_frame(1'b1);
    check("inten_int", intensity, 8'h20);
    check("inten_red", red, 8'h12);
    check("inten_err_flag", err_flag, 1'b1);

    e0 = err_cnt;
    set_frame(3, 8'h80, 8'h33, 8'h44, 8'h00, 8'h00); send_frame(1'b0);
    check("overrun_int", intensity, 8'h20);
    check("overrun_err_count", err_cnt - e0, 1);

    e0 = err_cnt;
    set_frame(1, 8'hC0, 8'h00, 8'h00, 8'h00, 8'h00); send_frame(1'b0);
    check("illegal_err_count", err_cnt - e0, 1);

    u0 = upd_cnt; e0 = err_cnt;
    set_frame(0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00); send_frame(1'b0);
    check("empty_upd_count", upd_cnt - u0, 0);
    check("empty_err_count", err_cnt - e0, 0);

    if (CHK) begin
      set_frame(3, 8'h80, 8'h10, 8'h90, 8'h00, 8'h00); send_frame(1'b0);
      check("chk_good_int", intensity, 8'h10);
      e0 = err_cnt;
      set_frame(3, 8'h80, 8'h10, 8'h91, 8'h00, 8'h00); send_frame(1'b0);
      check("chk_bad_int", intensity, 8'h10);
      check("chk_bad_err_count", err_cnt - e0, 1);
    end

    // Reset mid-frame, then a complete frame while cs stays low: nothing may commit
    u0 = upd_cnt;
    cs = 1'b0;
    repeat (4) tick();
    send_byte(8'h40);
    send_byte(8'hAA);
    do_reset();
    repeat (3) tick();
    send_byte(8'h40); send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
    if (CHK) send_byte(8'h44);
    cs = 1'b1;
    repeat (8) tick();
    check("rstmid_upd_count", upd_cnt - u0, 0);
    check("rstmid_red", red, 8'h00);
    check("rstmid_int", intensity, 8'hFF);
    check("rstmid_err_flag", err_flag, 1'b0);

    for (int f = 0; f < 80; f++) begin
      fq.delete();
      if ($urandom_range(0, 9) < 6) begin
        op = 2'($urandom_range(0, 2));
        fq.push_back({op, 6'($urandom)});
        repeat ((op == 2'b01) ? 4 : ((op == 2'b10) ? 1 : 0)) fq.push_back(8'($urandom));
        send_frame(1'b1);
      end else begin
        repeat ($urandom_range(0, 6)) fq.push_back(8'($urandom));
        send_frame($urandom_range(0, 1) == 1);
      end
    end

    repeat (4) tick();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
